// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program counter and fetch sequencer for the 8-bit core. Holds
//            the architectural PC, issues fetch requests with a valid/ready
//            handshake, and applies jump / branch redirects. A redirect that
//            arrives while no fetch is accepted is parked in a one-entry
//            pending register until the next accept.
// Ports    : clk, rst_n (sync, active-low)
//            en, halt_req            - run control
//            branch_taken, br_addr   - branch redirect from the branch adder
//            jump, jump_addr         - absolute jump redirect
//            fetch_ready/fetch_valid - instruction memory handshake
//            pc, pc_plus2            - fetch address and pc + PC_STEP
//            halted, pc_wrap         - status outputs
// Option   : define PC_LINK_REG_EN to add link_save, link_ret and link_addr
//            (a single link register for call/return).
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              PC_STEP   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            halt_req,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] br_addr,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            fetch_ready,
`ifdef PC_LINK_REG_EN
  input  logic            link_save,
  input  logic            link_ret,
  output logic [PC_W-1:0] link_addr,
`endif
  output logic            fetch_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus2,
  output logic            halted,
  output logic            pc_wrap
);

  localparam logic [PC_W:0] STEP_EXT = PC_STEP[PC_W:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            pend_valid;
  logic [PC_W-1:0] pend_addr;
  logic [PC_W:0]   step_sum;
  logic            step_carry;
  logic            accept;
  logic            redir;
  logic [PC_W-1:0] redir_tgt;
  logic            capture_ok;

  // Extra carry bit detects the modulo wrap of a sequential step.
  always_comb begin
    step_sum   = {1'b0, pc} + STEP_EXT;
    pc_plus2   = step_sum[PC_W-1:0];
    step_carry = step_sum[PC_W];
  end

  // Same-cycle redirect selection: jump > link_ret > branch.
  always_comb begin
    redir     = 1'b0;
    redir_tgt = jump_addr;
    if (jump) begin
      redir     = 1'b1;
      redir_tgt = jump_addr;
    end
`ifdef PC_LINK_REG_EN
    else if (link_ret) begin
      redir     = 1'b1;
      redir_tgt = link_addr;
    end
`endif
    else if (branch_taken) begin
      redir     = 1'b1;
      redir_tgt = br_addr;
    end
  end

  always_comb begin
    state_nxt   = state;
    fetch_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE: begin
        if (halt_req)  state_nxt = HALT;
        else if (en)   state_nxt = RUN;
      end
      RUN: begin
        fetch_valid = 1'b1;
        if (halt_req)  state_nxt = HALT;
        else if (!en)  state_nxt = IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = fetch_valid & fetch_ready;

  // A redirect that is not accepted is kept only if the unit is not halting;
  // a halt makes it unreachable anyway.
  assign capture_ok = (state != HALT) && !halt_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_VEC;
      pc_wrap    <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= RESET_VEC;
`ifdef PC_LINK_REG_EN
      link_addr  <= RESET_VEC;
`endif
    end else begin
      state   <= state_nxt;
      pc_wrap <= 1'b0;
      if (accept) begin
        pend_valid <= 1'b0;
        if (redir) begin
          pc <= redir_tgt;
        end else if (pend_valid) begin
          pc <= pend_addr;
        end else begin
          pc      <= pc_plus2;
          pc_wrap <= step_carry;
        end
      end else if (redir && capture_ok) begin
        pend_valid <= 1'b1;
        pend_addr  <= redir_tgt;
      end
`ifdef PC_LINK_REG_EN
      // Link is saved on the same edge the jump is taken or parked.
      if (jump && link_save && (accept || capture_ok)) begin
        link_addr <= pc_plus2;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Directed testbench for pc_fetch_unit. The driver applies one
//            input vector per cycle and queues the hand-computed outputs
//            expected after that edge; a separate monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       halt_req = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] br_addr = 8'h00;
  logic       jump = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic       fetch_ready = 1'b0;
  logic       fetch_valid;
  logic [7:0] pc;
  logic [7:0] pc_plus2;
  logic       halted;
  logic       pc_wrap;
`ifdef PC_LINK_REG_EN
  logic       link_save = 1'b0;
  logic       link_ret = 1'b0;
  logic [7:0] link_addr;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic       fv;
    logic       hl;
    logic       wr;
  } exp_t;

  exp_t exp_q[$];

  pc_fetch_unit #(.PC_W(8), .RESET_VEC(8'h00), .PC_STEP(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .halt_req     (halt_req),
    .branch_taken (branch_taken),
    .br_addr      (br_addr),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .fetch_ready  (fetch_ready),
`ifdef PC_LINK_REG_EN
    .link_save    (link_save),
    .link_ret     (link_ret),
    .link_addr    (link_addr),
`endif
    .fetch_valid  (fetch_valid),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .halted       (halted),
    .pc_wrap      (pc_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after every edge, compare against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".pc"},       {24'd0, pc},       {24'd0, e.pc});
      chk({e.name, ".pc_plus2"}, {24'd0, pc_plus2}, {24'd0, 8'(e.pc + 8'd2)});
      chk({e.name, ".valid"},    {31'd0, fetch_valid}, {31'd0, e.fv});
      chk({e.name, ".halted"},   {31'd0, halted},   {31'd0, e.hl});
      chk({e.name, ".wrap"},     {31'd0, pc_wrap},  {31'd0, e.wr});
    end
  end

  // Queue the outputs expected after the next edge, then let that edge pass.
  task automatic cyc(input string name, input logic [7:0] epc, input logic efv,
                     input logic ehl, input logic ewr);
    exp_t e;
    e.name = name; e.pc = epc; e.fv = efv; e.hl = ehl; e.wr = ewr;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic clr_pulses();
    jump = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
`ifdef PC_LINK_REG_EN
    link_save = 1'b0; link_ret = 1'b0;
`endif
  endtask

  initial begin
    // Reset
    rst_n = 1'b0; en = 1'b1; fetch_ready = 1'b1;
    cyc("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    // First edge out of reset: enters RUN, no accept yet
    rst_n = 1'b1;
    cyc("run_entry", 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) cyc("seq", 8'(2 * i), 1'b1, 1'b0, 1'b0);

    // Stall at 10 with a branch pulse, then release
    fetch_ready = 1'b0; branch_taken = 1'b1; br_addr = 8'h40;
    cyc("stall_br", 8'h10, 1'b1, 1'b0, 1'b0);
    clr_pulses();
    cyc("stall2", 8'h10, 1'b1, 1'b0, 1'b0);
    cyc("stall3", 8'h10, 1'b1, 1'b0, 1'b0);
    fetch_ready = 1'b1;
    cyc("pend_br", 8'h40, 1'b1, 1'b0, 1'b0);
    cyc("after_pend", 8'h42, 1'b1, 1'b0, 1'b0);

    // Jump beats branch in the same cycle
    jump = 1'b1; jump_addr = 8'h80; branch_taken = 1'b1; br_addr = 8'h40;
    cyc("jmp_vs_br", 8'h80, 1'b1, 1'b0, 1'b0);
    clr_pulses();

    // Wrap from FE, twice; a redirect to 00 must not pulse wrap
    jump = 1'b1; jump_addr = 8'hFE;
    cyc("jmp_fe", 8'hFE, 1'b1, 1'b0, 1'b0);
    clr_pulses();
    cyc("wrap1", 8'h00, 1'b1, 1'b0, 1'b1);
    cyc("post_wrap1", 8'h02, 1'b1, 1'b0, 1'b0);
    jump = 1'b1; jump_addr = 8'hFE;
    cyc("jmp_fe2", 8'hFE, 1'b1, 1'b0, 1'b0);
    clr_pulses();
    cyc("wrap2", 8'h00, 1'b1, 1'b0, 1'b1);
    cyc("post_wrap2", 8'h02, 1'b1, 1'b0, 1'b0);
    jump = 1'b1; jump_addr = 8'h00;
    cyc("jmp_00_nowrap", 8'h00, 1'b1, 1'b0, 1'b0);
    clr_pulses();

    // en=0 with accept: pc update lands, unit goes IDLE
    en = 1'b0;
    cyc("en_off_acc", 8'h02, 1'b0, 1'b0, 1'b0);
    jump = 1'b1; jump_addr = 8'h20;
    cyc("idle_jmp", 8'h02, 1'b0, 1'b0, 1'b0);
    clr_pulses();
    cyc("idle_hold", 8'h02, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    cyc("rerun", 8'h02, 1'b1, 1'b0, 1'b0);
    cyc("pend_jmp", 8'h20, 1'b1, 1'b0, 1'b0);

    // Halt with accept at pc=20
    halt_req = 1'b1;
    cyc("halt_acc", 8'h22, 1'b0, 1'b1, 1'b0);
    clr_pulses();
    jump = 1'b1; jump_addr = 8'h55;
    cyc("halt_ign_jmp", 8'h22, 1'b0, 1'b1, 1'b0);
    clr_pulses();
    cyc("halt_hold", 8'h22, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc("rst_from_halt", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; en = 1'b0;
    cyc("idle_after_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    // Halt from IDLE
    halt_req = 1'b1;
    cyc("halt_idle", 8'h00, 1'b0, 1'b1, 1'b0);
    clr_pulses();
    rst_n = 1'b0;
    cyc("rst2", 8'h00, 1'b0, 1'b0, 1'b0);

    // Later redirect overwrites a pending one
    rst_n = 1'b1; en = 1'b1; fetch_ready = 1'b0;
    cyc("run2", 8'h00, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b1; br_addr = 8'h40;
    cyc("pend_br2", 8'h00, 1'b1, 1'b0, 1'b0);
    clr_pulses();
    jump = 1'b1; jump_addr = 8'h70;
    cyc("pend_over", 8'h00, 1'b1, 1'b0, 1'b0);
    clr_pulses();
    fetch_ready = 1'b1;
    cyc("take_over", 8'h70, 1'b1, 1'b0, 1'b0);
    cyc("step_over", 8'h72, 1'b1, 1'b0, 1'b0);

    // Stalled redirect together with halt_req is discarded
    fetch_ready = 1'b0; halt_req = 1'b1; branch_taken = 1'b1; br_addr = 8'h99;
    cyc("halt_stall", 8'h72, 1'b0, 1'b1, 1'b0);
    clr_pulses();
    cyc("halt_stall2", 8'h72, 1'b0, 1'b1, 1'b0);

`ifdef PC_LINK_REG_EN
    rst_n = 1'b0; fetch_ready = 1'b1;
    cyc("rst_link", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("link_reset", {24'd0, link_addr}, 32'h00);
    rst_n = 1'b1;
    cyc("run_link", 8'h00, 1'b1, 1'b0, 1'b0);
    jump = 1'b1; jump_addr = 8'h30;
    cyc("jmp30", 8'h30, 1'b1, 1'b0, 1'b0);
    jump_addr = 8'h90; link_save = 1'b1;
    cyc("jal90", 8'h90, 1'b1, 1'b0, 1'b0);
    clr_pulses();
    chk("link_addr", {24'd0, link_addr}, 32'h32);
    cyc("step92", 8'h92, 1'b1, 1'b0, 1'b0);
    link_ret = 1'b1; branch_taken = 1'b1; br_addr = 8'h44;
    cyc("ret", 8'h32, 1'b1, 1'b0, 1'b0);
    clr_pulses();
`endif

    clr_pulses();
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage of the 8-bit core.
- Holds the architectural PC and issues fetch requests to instruction memory with a valid/ready handshake.
- Drives pc_plus2 to the branch-target adder and accepts the computed branch target back. Also accepts absolute jump targets.
- Sits directly upstream of the operand muxes and the branch adder: every instruction address in the datapath originates here.

Parameters:
- PC_W, 8, width of PC and all address ports
- RESET_VEC, 8'h00, PC value loaded on reset
- PC_STEP, 2, sequential increment per accepted fetch

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- en  input  1  run enable; leaves IDLE, low returns RUN to IDLE
- halt_req  input  1  single-cycle pulse, request permanent stop
- branch_taken  input  1  single-cycle pulse, redirect to br_addr
- br_addr  input  PC_W  branch target (pc_plus2 + offset, from branch adder)
- jump  input  1  single-cycle pulse, redirect to jump_addr
- jump_addr  input  PC_W  absolute jump target
- fetch_ready  input  1  instruction memory accepts request this cycle
- fetch_valid  output  1  fetch request valid, address = pc
- pc  output  PC_W  current fetch address
- pc_plus2  output  PC_W  pc + PC_STEP, modulo 2^PC_W, combinational from pc
- halted  output  1  high while in HALT
- pc_wrap  output  1  one-cycle pulse when a sequential step wraps past 2^PC_W-1

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous, active-low, on rst_n sampled at the clk rising edge.
  - Reset overrides everything, including mid-handshake and mid-redirect.
  - Reset values: pc=RESET_VEC, pc_plus2=RESET_VEC+PC_STEP, fetch_valid=0, halted=0, pc_wrap=0, state=IDLE, pending redirect cleared.
- States:
  - IDLE: fetch_valid=0, pc held. en=1 moves to RUN next cycle.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0, halted=1, pc frozen. Exits only via reset.
- Handshake: a fetch is accepted in a cycle where fetch_valid & fetch_ready. pc updates only on an accepted fetch, so latency is one cycle from acceptance to the new pc.
- Next-PC priority on accept:
  1. jump this cycle
  2. branch_taken this cycle
  3. pending redirect
  4. pc + PC_STEP
- Redirect while stalled:
  - If jump or branch_taken arrives in a cycle with no accept (stall, IDLE), the target is captured in a one-entry pending register.
  - A later redirect overwrites the pending one; jump beats branch in the same cycle.
  - Pending is consumed and cleared on the next accept.
  - Redirects arriving in HALT are ignored.
- Arithmetic: all PC math is modulo 2^PC_W. A sequential step from 8'hFE yields 8'h00 and pulses pc_wrap in the cycle pc becomes 8'h00. Redirects never pulse pc_wrap.
- en=0 in RUN: return to IDLE at the next edge. If an accept occurs in that same cycle, the pc update still takes effect. Pending redirect is retained.
- halt_req:
  - In RUN: the pc update from an accept in the same cycle completes, then the state becomes HALT.
  - In IDLE: go directly to HALT.
  - Simultaneous halt_req and redirect: the redirect is applied if accepted, otherwise discarded.
- fetch_valid must not drop in RUN without an accept unless en=0 or halt_req.

Optional Feature:
PC_LINK_REG_EN
- Defined: adds ports link_save (input, 1), link_ret (input, 1 pulse) and link_addr (output, PC_W).
  - On jump with link_save=1, link_addr is loaded with pc_plus2 at the same edge as the redirect.
  - link_ret is a redirect to link_addr, with priority between jump and branch_taken, and obeys the pending rules above.
  - link_addr resets to RESET_VEC.
- Undefined: these ports and the link register do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset then en=1, fetch_ready=1 for 4 cycles -> fetch_valid rises 1 cycle after en; pc sequence 00,02,04,06; pc_plus2 always pc+2.
- RUN with pc=10, fetch_ready=0 for 3 cycles while branch_taken pulses with br_addr=40, then ready=1 -> pc holds 10 during stall; next pc=40; no further redirect afterwards.
- Same cycle: jump with jump_addr=80, branch_taken with br_addr=40, fetch_ready=1 -> next pc=80.
- pc=FE, fetch_ready=1 -> pc=00, pc_wrap high exactly one cycle. Then jump to FE and step -> wrap pulses again.
- halt_req with accept at pc=20 -> pc=22, halted=1, fetch_valid=0 thereafter; jump pulses ignored. rst_n=0 for one edge -> pc=00, state IDLE.
- (PC_LINK_REG_EN) pc=30, jump+link_save to 90 -> link_addr=32; later link_ret with accept -> pc=32.
